// File: rtl/vout_pkg.sv
// vout_pkg: shared segment constants, state encoding, pipeline record and segment-select helper
package vout_pkg;
    localparam int NSEG = 6;
    localparam int SEG_IDX_W = 3;

    typedef enum logic {WAIT_VS, SYNCED} state_t;

    typedef struct packed {
        logic                 hs;
        logic                 vs;
        logic                 de;
        logic [15:0]          line;
        logic [SEG_IDX_W-1:0] idx;
        logic                 rd;
        logic                 uf;
    } pipe_t;

    function automatic logic [SEG_IDX_W-1:0] onehot_to_idx(input logic [NSEG-1:0] v);
        logic [SEG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NSEG - 1; i >= 0; i--)
            if (v[i]) idx = SEG_IDX_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/vout_delay_line.sv
// vout_delay_line: W-bit wide, D-deep shift register with synchronous clear
module vout_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr [D];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[D-1];
endmodule

// File: rtl/vout_segment_merge.sv
// vout_segment_merge: gated reads of six segment FIFOs merged into one re-timed pixel stream
module vout_segment_merge
    import vout_pkg::*;
#(
    parameter int                DATA_W    = 24,
    parameter int                FIFO_LAT  = 1,
    parameter logic [DATA_W-1:0] BLANK_VAL = '0
) (
    input  logic                   dp_clk,
    input  logic                   rst,
    input  logic [NSEG-1:0]        rdreq_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   de_in,
    input  logic [15:0]            line_in,
    input  logic [NSEG-1:0]        fifo_empty,
    input  logic [NSEG*DATA_W-1:0] fifo_q,
    output logic [NSEG-1:0]        fifo_rdreq,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   de_out,
    output logic [DATA_W-1:0]      rgb_out,
    output logic [15:0]            line_out,
    input  logic                   clear_err,
    output logic                   underflow_sticky,
    output logic                   frame_underflow,
    output logic [15:0]            underflow_cnt,
    output logic                   seg_err_sticky
);
    state_t              state;
    logic                vs_prev;
    logic                frame_flag;
    logic                synced;
    logic                vs_rise;
    logic                multi;
    logic                uf;
    logic [NSEG-1:0]     low;
    logic [DATA_W-1:0]   q_arr [NSEG];
    logic [DATA_W-1:0]   seg_q;
    pipe_t               p_in;
    pipe_t               p_d;

    assign synced  = state == SYNCED;
    assign vs_rise = vs_in & ~vs_prev;
    // isolate the lowest set strobe so a multi-hot request reads only one FIFO
    assign low        = rdreq_in & (~rdreq_in + NSEG'(1));
    assign multi      = (rdreq_in & ~low) != '0;
    assign uf         = synced & |(low & fifo_empty);
    assign fifo_rdreq = synced ? low & ~fifo_empty : '0;

    assign p_in = '{
        hs:   hs_in,
        vs:   vs_in,
        de:   de_in & synced,
        line: line_in,
        idx:  onehot_to_idx(rdreq_in),
        rd:   |fifo_rdreq,
        uf:   uf
    };

    vout_delay_line #(.W($bits(pipe_t)), .D(FIFO_LAT)) u_dly (
        .clk (dp_clk),
        .rst (rst),
        .d   (p_in),
        .q   (p_d)
    );

    for (genvar g = 0; g < NSEG; g++) begin : g_q
        assign q_arr[g] = fifo_q[g*DATA_W +: DATA_W];
    end
    assign seg_q = q_arr[p_d.idx];

    always_ff @(posedge dp_clk) begin
        if (rst) begin
            hs_out   <= 1'b0;
            vs_out   <= 1'b0;
            de_out   <= 1'b0;
            line_out <= '0;
            rgb_out  <= BLANK_VAL;
        end else begin
            hs_out   <= p_d.hs;
            vs_out   <= p_d.vs;
            de_out   <= p_d.de;
            line_out <= p_d.line;
            rgb_out  <= (p_d.de & p_d.rd & ~p_d.uf) ? seg_q : BLANK_VAL;
        end
    end

    always_ff @(posedge dp_clk) begin
        if (rst) begin
            state            <= WAIT_VS;
            vs_prev          <= 1'b0;
            frame_flag       <= 1'b0;
            frame_underflow  <= 1'b0;
            underflow_sticky <= 1'b0;
            seg_err_sticky   <= 1'b0;
            underflow_cnt    <= '0;
        end else begin
            vs_prev    <= vs_in;
            frame_flag <= (synced & vs_rise) ? 1'b0 : frame_flag | uf;
            if (!synced && vs_rise) state <= SYNCED;
            if (clear_err) begin
                frame_underflow  <= 1'b0;
                underflow_sticky <= 1'b0;
                seg_err_sticky   <= 1'b0;
                underflow_cnt    <= '0;
            end else begin
                if (uf) begin
                    underflow_sticky <= 1'b1;
                    if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
                end
                if (multi) seg_err_sticky <= 1'b1;
                if (synced && vs_rise) frame_underflow <= frame_flag | uf;
            end
        end
    end
endmodule

// File: tb/tb_vout_segment_merge.sv
// tb_vout_segment_merge: random and directed stimulus on FIFO_LAT=1 and FIFO_LAT=3 instances vs a cycle-history model
module tb_vout_segment_merge;
    localparam int NMAX = 1 << 17;

    logic         dp_clk = 1'b0;
    logic         rst, hs_in, vs_in, de_in, clear_err;
    logic [5:0]   rdreq_in, fifo_empty;
    logic [15:0]  line_in;
    logic [143:0] fifo_q;

    logic [5:0]  frd1, frd3;
    logic        hs1, vs1, de1, us1, fu1, se1;
    logic        hs3, vs3, de3, us3, fu3, se3;
    logic [23:0] rgb1, rgb3;
    logic [15:0] ln1, ln3, cnt1, cnt3;

    int total = 0, bad = 0, n = 0, last_rst = 0;
    logic hold_q = 1'b0;

    logic         h_rd [NMAX];
    logic         h_de [NMAX];
    logic         h_hs [NMAX];
    logic         h_vs [NMAX];
    int           h_seg [NMAX];
    logic [15:0]  h_line [NMAX];
    logic [143:0] h_q [NMAX];

    logic        m_sync = 0, m_vsprev = 0, m_ff = 0, m_sticky = 0, m_seg = 0, m_fu = 0;
    logic [15:0] m_cnt = 0;

    always #5 dp_clk = ~dp_clk;

    vout_segment_merge #(.FIFO_LAT(1)) u1 (
        .dp_clk(dp_clk), .rst(rst), .rdreq_in(rdreq_in), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .line_in(line_in), .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(frd1),
        .hs_out(hs1), .vs_out(vs1), .de_out(de1), .rgb_out(rgb1), .line_out(ln1), .clear_err(clear_err),
        .underflow_sticky(us1), .frame_underflow(fu1), .underflow_cnt(cnt1), .seg_err_sticky(se1)
    );

    vout_segment_merge #(.FIFO_LAT(3)) u3 (
        .dp_clk(dp_clk), .rst(rst), .rdreq_in(rdreq_in), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .line_in(line_in), .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(frd3),
        .hs_out(hs3), .vs_out(vs3), .de_out(de3), .rgb_out(rgb3), .line_out(ln3), .clear_err(clear_err),
        .underflow_sticky(us3), .frame_underflow(fu3), .underflow_cnt(cnt3), .seg_err_sticky(se3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_inst(input int lat, input string nm, input logic [5:0] e_frd, input logic [5:0] frd,
                              input logic hs, input logic vs, input logic de, input logic [23:0] rgb,
                              input logic [15:0] line, input logic st, input logic fu, input logic se,
                              input logic [15:0] cnt);
        int m;
        logic z;
        logic [143:0] qq;
        logic [23:0] e_rgb;
        m = n - lat - 1;
        z = (m < 0) || (last_rst >= m);
        if (z) m = 0;
        qq = h_q[n-1];
        e_rgb = (!z && h_de[m] && h_rd[m]) ? qq[h_seg[m]*24 +: 24] : 24'h0;
        chk({nm, ".fifo_rdreq"}, 64'(frd), 64'(e_frd));
        chk({nm, ".hs"}, 64'(hs), z ? 64'(0) : 64'(h_hs[m]));
        chk({nm, ".vs"}, 64'(vs), z ? 64'(0) : 64'(h_vs[m]));
        chk({nm, ".de"}, 64'(de), z ? 64'(0) : 64'(h_de[m]));
        chk({nm, ".line"}, 64'(line), z ? 64'(0) : 64'(h_line[m]));
        chk({nm, ".rgb"}, 64'(rgb), 64'(e_rgb));
        chk({nm, ".uf_sticky"}, 64'(st), 64'(m_sticky));
        chk({nm, ".frame_uf"}, 64'(fu), 64'(m_fu));
        chk({nm, ".seg_err"}, 64'(se), 64'(m_seg));
        chk({nm, ".uf_cnt"}, 64'(cnt), 64'(m_cnt));
    endtask

    task automatic tick();
        int sel, ones;
        logic [5:0] e_frd;
        logic uf, rise, rd;
        #1;
        sel = -1;
        ones = 0;
        for (int i = 5; i >= 0; i--) if (rdreq_in[i]) begin sel = i; ones++; end
        rd = m_sync && sel >= 0 && !fifo_empty[sel];
        uf = m_sync && sel >= 0 && fifo_empty[sel];
        e_frd = rd ? 6'(1 << sel) : 6'd0;
        if (n > 0) begin
            check_inst(1, "u1", e_frd, frd1, hs1, vs1, de1, rgb1, ln1, us1, fu1, se1, cnt1);
            check_inst(3, "u3", e_frd, frd3, hs3, vs3, de3, rgb3, ln3, us3, fu3, se3, cnt3);
        end
        h_hs[n] = hs_in;
        h_vs[n] = vs_in;
        h_de[n] = de_in && m_sync;
        h_line[n] = line_in;
        h_rd[n] = rd;
        h_seg[n] = sel < 0 ? 0 : sel;
        h_q[n] = fifo_q;
        rise = vs_in && !m_vsprev;
        if (rst) begin
            last_rst = n;
            {m_sync, m_vsprev, m_ff, m_sticky, m_seg, m_fu} = '0;
            m_cnt = 0;
        end else begin
            if (clear_err) begin
                m_cnt = 0;
                {m_sticky, m_seg, m_fu} = '0;
            end else begin
                if (uf) begin
                    m_sticky = 1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
                if (ones > 1) m_seg = 1;
                if (m_sync && rise) m_fu = m_ff || uf;
            end
            if (m_sync && rise) m_ff = 0;
            else if (uf) m_ff = 1;
            if (rise) m_sync = 1;
            m_vsprev = vs_in;
        end
        n++;
        @(negedge dp_clk);
    endtask

    task automatic go(input logic [5:0] rq, input logic [5:0] em, input logic de, input logic vs, input int k);
        for (int i = 0; i < k; i++) begin
            rdreq_in = rq;
            fifo_empty = em;
            de_in = de;
            vs_in = vs;
            hs_in = 1'($urandom);
            line_in = 16'($urandom);
            for (int j = 0; j < 6; j++) fifo_q[j*24 +: 24] = 24'($urandom);
            if (hold_q) begin
                fifo_q[23:0] = 24'h112233;
                fifo_q[47:24] = 24'hAABBCC;
            end
            tick();
        end
    endtask

    task automatic scen2();
        hold_q = 1;
        go(6'b000001, 6'b0, 1, 0, 1);
        go(6'b000010, 6'b0, 1, 0, 1);
        chk("s2_rgb1_first", 64'(rgb1), 64'h112233);
        chk("s2_de1_first", 64'(de1), 64'(1));
        go(6'b0, 6'b0, 0, 0, 1);
        chk("s2_rgb1_second", 64'(rgb1), 64'hAABBCC);
        chk("s2_de1_second", 64'(de1), 64'(1));
        go(6'b0, 6'b0, 0, 0, 1);
        chk("s2_rgb3_first", 64'(rgb3), 64'h112233);
        chk("s2_de3_first", 64'(de3), 64'(1));
        go(6'b0, 6'b0, 0, 0, 1);
        chk("s2_rgb3_second", 64'(rgb3), 64'hAABBCC);
        chk("s2_de3_second", 64'(de3), 64'(1));
        hold_q = 0;
    endtask

    initial begin
        rst = 1; clear_err = 0; hs_in = 0; vs_in = 0; de_in = 0; line_in = 0;
        rdreq_in = 0; fifo_empty = 0; fifo_q = '0;
        tick();
        tick();
        rst = 0;
        // frame-start synchronisation: no reads or de before the first vs rising edge
        go(6'b000001, 6'b0, 1, 0, 4);
        chk("wait_frd", 64'(frd1), 64'(0));
        chk("wait_de", 64'(de1), 64'(0));
        go(6'b0, 6'b0, 0, 1, 1);
        go(6'b0, 6'b0, 0, 0, 2);
        rdreq_in = 6'b000001;
        fifo_empty = 0;
        #1;
        chk("synced_frd", 64'(frd1), 64'(6'b000001));
        tick();
        scen2();
        go(6'b000100, 6'b000100, 1, 0, 1);
        chk("uf_frd_gated", 64'(frd1), 64'(0));
        go(6'b000100, 6'b000100, 1, 0, 2);
        chk("uf_cnt3", 64'(cnt1), 64'(3));
        chk("uf_sticky", 64'(us1), 64'(1));
        go(6'b0, 6'b0, 0, 0, 2);
        go(6'b0, 6'b0, 0, 1, 1);
        chk("frame_uf_set", 64'(fu1), 64'(1));
        go(6'b000001, 6'b0, 1, 0, 3);
        go(6'b0, 6'b0, 0, 1, 1);
        chk("frame_uf_clean", 64'(fu1), 64'(0));
        go(6'b000011, 6'b0, 1, 0, 1);
        chk("multi_frd", 64'(frd1), 64'(6'b000001));
        chk("multi_seg_err", 64'(se1), 64'(1));
        go(6'b0, 6'b0, 0, 0, 2);
        clear_err = 1;
        go(6'b0, 6'b0, 0, 0, 1);
        clear_err = 0;
        chk("clr_seg_err", 64'(se1), 64'(0));
        chk("clr_cnt", 64'(cnt1), 64'(0));
        chk("clr_sticky", 64'(us1), 64'(0));
        go(6'b000100, 6'b000100, 1, 0, 65537);
        chk("sat_cnt1", 64'(cnt1), 64'hFFFF);
        chk("sat_cnt3", 64'(cnt3), 64'hFFFF);
        clear_err = 1;
        go(6'b000100, 6'b000100, 1, 0, 1);
        clear_err = 0;
        chk("clr_vs_uf_cnt", 64'(cnt1), 64'(0));
        chk("clr_vs_uf_sticky", 64'(us1), 64'(0));
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [5:0] rq, em;
            r = $urandom_range(0, 9);
            rq = (r == 0) ? 6'd0 : (r == 1) ? 6'($urandom_range(0, 63)) : 6'(1 << $urandom_range(0, 5));
            em = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            clear_err = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 99) == 0);
            go(rq, em, 1'($urandom), $urandom_range(0, 15) == 0, 1);
        end
        rst = 0;
        clear_err = 0;
        go(6'b0, 6'b0, 0, 0, 1);
        go(6'b0, 6'b0, 0, 1, 1);
        go(6'b000001, 6'b0, 1, 0, 4);
        chk("pre_rst_de", 64'(de1), 64'(1));
        rst = 1;
        go(6'b000001, 6'b0, 1, 0, 1);
        rst = 0;
        chk("post_rst_de1", 64'(de1), 64'(0));
        chk("post_rst_rgb1", 64'(rgb1), 64'(0));
        chk("post_rst_de3", 64'(de3), 64'(0));
        go(6'b000001, 6'b0, 1, 0, 6);
        chk("no_vs_de1", 64'(de1), 64'(0));
        chk("no_vs_de3", 64'(de3), 64'(0));
        go(6'b0, 6'b0, 0, 1, 1);
        go(6'b0, 6'b0, 0, 0, 1);
        scen2();
        go(6'b0, 6'b0, 0, 0, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vout_segment_merge.md
Name: vout_segment_merge

Overview:
- Sits directly downstream of the display timing generator.
- Consumes its per-segment read strobes rdreq[5:0] and its hs/vs/de/line_number.
- Issues guarded reads to six segment line FIFOs and muxes the returned words into one pixel stream, re-aligned with delayed hs/vs/de.
- Handles frame-start synchronisation, FIFO underflow accounting and strobe-overlap errors.

Parameters:
- DATA_W, 24, pixel word width.
- FIFO_LAT, 1, FIFO read latency in cycles from rdreq to q valid; legal range 1..3.
- BLANK_VAL, 0, pixel value driven when de_out=0 or on underflow/gap.

Ports:
- dp_clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active high.
- rdreq_in  in  6  segment read strobes from timing generator, at most one-hot.
- hs_in  in  1  timing hsync.
- vs_in  in  1  timing vsync.
- de_in  in  1  timing data enable.
- line_in  in  16  timing line_number.
- fifo_empty  in  6  per-segment FIFO empty.
- fifo_q  in  6*DATA_W  FIFO read data; segment i occupies bits [i*DATA_W +: DATA_W].
- fifo_rdreq  out  6  FIFO read enables.
- hs_out  out  1  delayed hsync.
- vs_out  out  1  delayed vsync.
- de_out  out  1  delayed data enable.
- rgb_out  out  DATA_W  pixel data.
- line_out  out  16  delayed line number.
- clear_err  in  1  clears the sticky flags and the counter.
- underflow_sticky  out  1  set on any underflow pixel.
- frame_underflow  out  1  underflow occurred in the last completed frame.
- underflow_cnt  out  16  saturating underflow pixel count.
- seg_err_sticky  out  1  set on a multi-hot rdreq_in.

Behaviour:
- Reset: all outputs 0, rgb_out=BLANK_VAL, state=WAIT_VS, all pipeline stages cleared.
- States:
  - WAIT_VS: fifo_rdreq=0, de_out forced 0, hs/vs/line still delayed through. Exit to SYNCED on the first cycle where vs_in=1 and the registered previous vs_in=0.
  - SYNCED: normal operation; no exit except rst.
- Read gating (combinational, SYNCED only): fifo_rdreq[i] = rdreq_in[i] & ~fifo_empty[i]. An empty FIFO is never read.
- Segment select: encode rdreq_in as a 3-bit index plus valid bit. Multi-hot: lowest index wins, only that FIFO is read, seg_err_sticky is set.
- Pipeline: index, valid, underflow bit, hs, vs, de, line pass through a FIFO_LAT-deep shift register, then one output register stage.
  - Total latency from inputs to outputs = FIFO_LAT+1 cycles for every output, so alignment is exact.
- Output pixel, at the stage where q is valid:
  - de_d=0 → BLANK_VAL.
  - de_d=1 with a valid read → selected segment's q.
  - de_d=1 with underflow, or with no strobe (gap) → BLANK_VAL.
- Underflow event: rdreq_in[i]=1 and fifo_empty[i]=1 in SYNCED. On each event:
  - underflow_cnt increments, saturating at 16'hFFFF.
  - underflow_sticky sets.
  - The internal frame flag sets.
- Frame boundary: on a vs_in rising edge in SYNCED, frame_underflow <= frame flag (including any event in that same cycle), then the frame flag clears.
- clear_err: clears underflow_sticky, seg_err_sticky, underflow_cnt and frame_underflow next cycle. It has priority over a simultaneous set/increment (result 0).
- Gaps: de_in=1 with no rdreq_in is not counted as underflow.
- Reset mid-frame: returns to WAIT_VS and clears the pipeline. The first output frame starts at the next vs_in rising edge. No partial frame with de_out=1 is emitted.

Decomposition:
- Shared package vout_pkg: NSEG=6, SEG_IDX_W=3, onehot-to-index function with lowest-wins priority, state encoding (WAIT_VS, SYNCED).
- One natural sub-module: vout_delay_line, a parameterised-width, parameterised-depth shift register with synchronous reset. It is used for the hs/vs/de/line/idx/valid bundle.

Test Plan:
1. Reset then stimulus before any vs rising edge, rdreq_in=6'b000001, FIFO non-empty → fifo_rdreq=0, de_out=0; after a vs_in 0→1, state SYNCED.
2. SYNCED, FIFO_LAT=1: rdreq_in=000001 at cycle t with q0=24'h112233 at t+1, then rdreq_in=000010 at t+1 with q1=24'hAABBCC → rgb_out=112233 at t+2 and AABBCC at t+3, with de_out aligned.
3. rdreq_in=000100 for 3 cycles with fifo_empty[2]=1 → fifo_rdreq[2]=0; rgb_out=BLANK_VAL for 3 pixels; underflow_cnt=3; sticky=1; frame_underflow=1 after the next vs rising edge and 0 after a following clean frame.
4. rdreq_in=000011 → fifo_rdreq=000001, segment 0 data output, seg_err_sticky=1; clear_err pulse → 0.
5. underflow_cnt preloaded to 16'hFFFE plus 3 underflows → saturates at 16'hFFFF; clear_err asserted together with an underflow → 0.
6. rst pulsed mid-line while de_out=1 → next cycle de_out=0, rgb_out=BLANK_VAL; no de_out until a vs_in rising edge; FIFO_LAT=3 rerun of scenario 2 gives latency 4.
